// File: rtl/sd_pkg.sv
// Shared constants, status codes, FSM state type and CRC step for the SD multi-block reader.
package sd_pkg;

  localparam logic [2:0] CMD17_SEL = 3'd3;
  localparam logic [2:0] CMD18_SEL = 3'd5;
  localparam logic [2:0] CMD12_SEL = 3'd6;

  localparam logic [7:0] ST_OK        = 8'h00;
  localparam logic [7:0] ST_R1_ERR    = 8'h01;
  localparam logic [7:0] ST_TIMEOUT   = 8'h02;
  localparam logic [7:0] ST_CRC_ERR   = 8'h03;
  localparam logic [7:0] ST_TOKEN_ERR = 8'h04;

  localparam logic [7:0] START_TOKEN = 8'hFE;

  typedef enum logic [3:0] {
    IDLE,
    SEND_CMD,
    WAIT_RESP,
    WAIT_TOKEN,
    RECV_DATA,
    RECV_CRC,
    NEXT_BLK,
    SEND_STOP,
    WAIT_STOP,
    DONE
  } state_t;

  // One serial step of CRC16-CCITT (poly 0x1021).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT accumulator with synchronous clear.
module sd_crc16
  import sd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= '0;
    end else if (i_clear) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_card_multi_read.sv
// SD single/multi-block read engine: issues CMD17/CMD18, collects blocks into a buffer,
// checks per-block CRC16 and terminates multi-block reads with CMD12.
module sd_card_multi_read
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int MEM_AW        = 32,
  parameter int CNT_W         = 8,
  parameter int TOKEN_TIMEOUT = 65535,
  parameter int CRC_EN        = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_read,
  input  logic [31:0]       i_addr,
  input  logic [CNT_W-1:0]  i_block_count,
  input  logic [MEM_AW-1:0] i_mem_base,
  input  logic [7:0]        i_accept_register,
  output logic [7:0]        o_data,
  output logic [MEM_AW-1:0] o_addr,
  output logic              o_wr_nrd,
  output logic              o_send_cmd,
  output logic [2:0]        o_cmd_select,
  output logic [31:0]       o_cmd_arg,
  input  logic              i_confirm_pin,
  input  logic [7:0]        i_response_status,
  output logic              o_read_done,
  output logic [7:0]        o_status,
  output logic              o_busy
);

  localparam int BCW = (BLOCK_BYTES < 2) ? 1 : $clog2(BLOCK_BYTES);
  localparam int TW  = (TOKEN_TIMEOUT < 2) ? 1 : $clog2(TOKEN_TIMEOUT);

  state_t            r_state, w_next;
  logic              r_multi;
  logic [CNT_W-1:0]  r_remaining;
  logic [2:0]        r_bit_cnt;
  logic [BCW-1:0]    r_byte_cnt;
  logic [3:0]        r_crc_cnt;
  logic [15:0]       r_crc_rx;
  logic [TW-1:0]     r_tmo;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_wr;
  logic [2:0]        r_cmd_sel;
  logic [31:0]       r_cmd_arg;
  logic [7:0]        r_status;

  logic              w_multi;
  logic [CNT_W-1:0]  w_count;
  logic              w_token_ok;
  logic              w_token_err;
  logic              w_tmo_hit;
  logic              w_byte_last;
  logic [15:0]       w_crc_rx;
  logic [15:0]       w_crc;
  logic              w_crc_bad;
  state_t            w_abort;

  assign w_multi     = i_block_count > CNT_W'(1);
  assign w_count     = (i_block_count == '0) ? CNT_W'(1) : i_block_count;
  assign w_token_ok  = i_accept_register == START_TOKEN;
  assign w_token_err = i_accept_register[7:4] == 4'b0000;
  assign w_tmo_hit   = r_tmo == TW'(TOKEN_TIMEOUT - 1);
  assign w_byte_last = (r_bit_cnt == 3'd7) && (r_byte_cnt == BCW'(BLOCK_BYTES - 1));
  assign w_crc_rx    = {r_crc_rx[14:0], i_accept_register[0]};
  assign w_crc_bad   = (CRC_EN != 0) && (w_crc_rx != w_crc);
  assign w_abort     = r_multi ? SEND_STOP : DONE;

  sd_crc16 u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (r_state == WAIT_TOKEN),
    .i_en    (r_state == RECV_DATA),
    .i_bit   (i_accept_register[0]),
    .o_crc   (w_crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (i_start_read) w_next = SEND_CMD;
      SEND_CMD:   w_next = WAIT_RESP;
      WAIT_RESP:  if (i_confirm_pin) w_next = (i_response_status == 8'h00) ? WAIT_TOKEN : DONE;
      WAIT_TOKEN: begin
        if (w_token_ok)       w_next = RECV_DATA;
        else if (w_token_err) w_next = w_abort;
        else if (w_tmo_hit)   w_next = w_abort;
      end
      RECV_DATA:  if (w_byte_last) w_next = RECV_CRC;
      RECV_CRC:   if (r_crc_cnt == 4'd15) w_next = w_crc_bad ? w_abort : NEXT_BLK;
      // r_remaining still counts the block just finished
      NEXT_BLK:   w_next = (r_remaining != CNT_W'(1)) ? WAIT_TOKEN : w_abort;
      SEND_STOP:  w_next = WAIT_STOP;
      WAIT_STOP:  if (i_confirm_pin) w_next = DONE;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_multi     <= 1'b0;
      r_remaining <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_crc_cnt   <= '0;
      r_crc_rx    <= '0;
      r_tmo       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr        <= 1'b0;
      r_cmd_sel   <= '0;
      r_cmd_arg   <= '0;
      r_status    <= '0;
    end else begin
      r_wr  <= 1'b0;
      r_tmo <= '0;
      // address advances the cycle after each write strobe
      if (r_wr) r_addr <= r_addr + MEM_AW'(1);
      case (r_state)
        IDLE: if (i_start_read) begin
          r_multi     <= w_multi;
          r_remaining <= w_count;
          r_addr      <= i_mem_base;
          r_status    <= ST_OK;
          r_cmd_sel   <= w_multi ? CMD18_SEL : CMD17_SEL;
          r_cmd_arg   <= i_addr;
        end
        WAIT_RESP: if (i_confirm_pin && i_response_status != 8'h00) r_status <= ST_R1_ERR;
        WAIT_TOKEN: begin
          r_tmo      <= r_tmo + TW'(1);
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
          if (!w_token_ok) begin
            if (w_token_err)    r_status <= ST_TOKEN_ERR;
            else if (w_tmo_hit) r_status <= ST_TIMEOUT;
          end
        end
        RECV_DATA: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          r_crc_cnt <= '0;
          if (r_bit_cnt == 3'd7) begin
            r_data     <= i_accept_register;
            r_wr       <= 1'b1;
            r_byte_cnt <= r_byte_cnt + BCW'(1);
          end
        end
        RECV_CRC: begin
          r_crc_rx  <= w_crc_rx;
          r_crc_cnt <= r_crc_cnt + 4'd1;
          if (r_crc_cnt == 4'd15 && w_crc_bad) r_status <= ST_CRC_ERR;
        end
        NEXT_BLK: r_remaining <= r_remaining - CNT_W'(1);
        default: ;
      endcase
      if (r_state != SEND_STOP && w_next == SEND_STOP) begin
        r_cmd_sel <= CMD12_SEL;
        r_cmd_arg <= '0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_addr       = r_addr;
  assign o_wr_nrd     = r_wr;
  assign o_send_cmd   = (r_state == SEND_CMD) || (r_state == SEND_STOP);
  assign o_cmd_select = r_cmd_sel;
  assign o_cmd_arg    = r_cmd_arg;
  assign o_read_done  = r_state == DONE;
  assign o_status     = r_status;
  assign o_busy       = r_state != IDLE;

endmodule

// File: tb/tb_sd_card_multi_read.sv
// Directed bench with randomized payloads for sd_card_multi_read, checked against a byte-level model.
module tb_sd_card_multi_read;
  import sd_pkg::*;

  localparam int BB  = 512;
  localparam int TMO = 100;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_start_read = 1'b0;
  logic [31:0] i_addr = '0;
  logic [7:0]  i_block_count = '0;
  logic [31:0] i_mem_base = '0;
  logic [7:0]  i_accept_register = 8'hFF;
  logic        i_confirm_pin = 1'b0;
  logic [7:0]  i_response_status = '0;
  logic [7:0]  o_data;
  logic [31:0] o_addr;
  logic        o_wr_nrd;
  logic        o_send_cmd;
  logic [2:0]  o_cmd_select;
  logic [31:0] o_cmd_arg;
  logic        o_read_done;
  logic [7:0]  o_status;
  logic        o_busy;

  sd_card_multi_read #(
    .BLOCK_BYTES  (BB),
    .MEM_AW       (32),
    .CNT_W        (8),
    .TOKEN_TIMEOUT(TMO),
    .CRC_EN       (1)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_start_read      (i_start_read),
    .i_addr            (i_addr),
    .i_block_count     (i_block_count),
    .i_mem_base        (i_mem_base),
    .i_accept_register (i_accept_register),
    .o_data            (o_data),
    .o_addr            (o_addr),
    .o_wr_nrd          (o_wr_nrd),
    .o_send_cmd        (o_send_cmd),
    .o_cmd_select      (o_cmd_select),
    .o_cmd_arg         (o_cmd_arg),
    .i_confirm_pin     (i_confirm_pin),
    .i_response_status (i_response_status),
    .o_read_done       (o_read_done),
    .o_status          (o_status),
    .o_busy            (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // MISO stream: 0/1 = shift bit in, 2 = line idle (register all ones), 3 = data-error token 8'h05
  int stream[$];
  initial forever begin
    int b;
    @(posedge i_clk); #1;
    if (stream.size() == 0) i_accept_register = 8'hFF;
    else begin
      b = stream.pop_front();
      if (b == 2)      i_accept_register = 8'hFF;
      else if (b == 3) i_accept_register = 8'h05;
      else             i_accept_register = {i_accept_register[6:0], b[0]};
    end
  end

  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          cmd_cnt = 0;
  int          done_cnt = 0;
  int          overlap_cnt = 0;
  initial forever begin
    @(negedge i_clk);
    if (o_wr_nrd) begin wr_addr_q.push_back(o_addr); wr_data_q.push_back(o_data); end
    if (o_send_cmd) cmd_cnt++;
    if (o_read_done) done_cnt++;
    if (o_wr_nrd && o_read_done) overlap_cnt++;
  end

  logic [31:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [31:0] next_addr;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic new_case(input logic [31:0] base);
    wr_addr_q.delete(); wr_data_q.delete(); exp_addr.delete(); exp_data.delete();
    cmd_cnt = 0; done_cnt = 0; overlap_cnt = 0; next_addr = base;
  endtask

  task automatic start(input logic [7:0] cnt, input logic [31:0] base, input logic [31:0] sector);
    i_start_read = 1'b1; i_block_count = cnt; i_mem_base = base; i_addr = sector;
    @(posedge i_clk); #1;
    i_start_read = 1'b0; i_addr = $urandom; i_mem_base = $urandom; i_block_count = 8'($urandom);
  endtask

  task automatic serve(input string tag, input logic [2:0] esel, input logic [31:0] earg,
                       input logic [7:0] resp, input int budget);
    int n = 0;
    while (!o_send_cmd && n < budget) begin @(posedge i_clk); #1; n++; end
    check({tag, "_cmd_seen"}, o_send_cmd, 1);
    check({tag, "_cmd_sel"}, o_cmd_select, esel);
    check({tag, "_cmd_arg"}, o_cmd_arg, earg);
    @(posedge i_clk); #1;
    check({tag, "_cmd_one_cycle"}, o_send_cmd, 0);
    @(posedge i_clk); #1;
    i_confirm_pin = 1'b1; i_response_status = resp;
    @(posedge i_clk); #1;
    i_confirm_pin = 1'b0; i_response_status = '0;
  endtask

  task automatic push_block(input bit rnd, input logic [7:0] fill, input bit flip, input bit want);
    logic [15:0] crc;
    logic [7:0]  d;
    crc = '0;
    repeat (4) stream.push_back(2);
    for (int i = 0; i < 8; i++) stream.push_back((i == 7) ? 0 : 1);
    for (int j = 0; j < BB; j++) begin
      d = rnd ? 8'($urandom) : fill;
      crc = crc_byte(crc, d);
      for (int b = 7; b >= 0; b--) stream.push_back(int'(d[b]));
      if (want) begin exp_addr.push_back(next_addr); exp_data.push_back(d); next_addr++; end
    end
    if (flip) crc[5] = ~crc[5];
    for (int b = 15; b >= 0; b--) stream.push_back(int'(crc[b]));
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (!o_read_done && n < budget) begin @(posedge i_clk); #1; n++; end
    check({tag, "_done_seen"}, o_read_done, 1);
  endtask

  task automatic finish_case(input string tag, input logic [7:0] st, input int ncmd);
    int nbad = 0;
    check({tag, "_status"}, o_status, st);
    @(posedge i_clk); #1;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_idle_after"}, {o_busy, o_read_done}, 2'b00);
    check({tag, "_cmd_count"}, cmd_cnt, ncmd);
    check({tag, "_wr_done_overlap"}, overlap_cnt, 0);
    check({tag, "_wr_count"}, wr_addr_q.size(), exp_addr.size());
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++)
      if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) nbad++;
    check({tag, "_wr_mismatches"}, nbad, 0);
    stream.delete();
    repeat (5) begin @(posedge i_clk); #1; end
    check({tag, "_status_held"}, o_status, st);
  endtask

  initial begin
    int n;
    logic [31:0] base, sec;

    #1 i_rst_n = 1'b0;
    #2;
    check("reset_out_a", {o_data, o_addr, o_wr_nrd, o_send_cmd, o_cmd_select}, '0);
    check("reset_out_b", {o_cmd_arg, o_read_done, o_status, o_busy}, '0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end

    // single block of 0x48
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd1, base, sec);
    serve("single", CMD17_SEL, sec, 8'h00, 10);
    push_block(1'b0, 8'h48, 1'b0, 1'b1);
    wait_done("single", 6000, n);
    finish_case("single", ST_OK, 1);

    // three blocks, address wraps past 2^32, stray start while busy
    base = 32'hFFFF_FF00; sec = $urandom;
    new_case(base);
    start(8'd3, base, sec);
    serve("multi3", CMD18_SEL, sec, 8'h00, 10);
    repeat (3) push_block(1'b1, 8'h00, 1'b0, 1'b1);
    i_start_read = 1'b1; @(posedge i_clk); #1; i_start_read = 1'b0;
    serve("multi3_stop", CMD12_SEL, 32'h0, 8'($urandom), 20000);
    wait_done("multi3", 100, n);
    finish_case("multi3", ST_OK, 2);

    // count 0 behaves as a single block
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd0, base, sec);
    serve("count0", CMD17_SEL, sec, 8'h00, 10);
    push_block(1'b1, 8'h00, 1'b0, 1'b1);
    wait_done("count0", 6000, n);
    finish_case("count0", ST_OK, 1);

    // R1 error
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd2, base, sec);
    serve("r1err", CMD18_SEL, sec, 8'h04, 10);
    wait_done("r1err", 10, n);
    check("r1err_latency_le2", n <= 2, 1'b1);
    finish_case("r1err", ST_R1_ERR, 1);

    // token timeout, single block
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd1, base, sec);
    serve("tmo1", CMD17_SEL, sec, 8'h00, 10);
    wait_done("tmo1", 400, n);
    check("tmo1_clocks", n, TMO);
    finish_case("tmo1", ST_TIMEOUT, 1);

    // token timeout, multi block
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd2, base, sec);
    serve("tmo2", CMD18_SEL, sec, 8'h00, 10);
    serve("tmo2_stop", CMD12_SEL, 32'h0, 8'h00, 400);
    wait_done("tmo2", 10, n);
    finish_case("tmo2", ST_TIMEOUT, 2);

    // data-error token on a multi-block read
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd4, base, sec);
    serve("tokerr", CMD18_SEL, sec, 8'h00, 10);
    stream.push_back(2); stream.push_back(2); stream.push_back(3);
    serve("tokerr_stop", CMD12_SEL, 32'h0, 8'h00, 200);
    wait_done("tokerr", 10, n);
    finish_case("tokerr", ST_TOKEN_ERR, 2);

    // CRC error in block 2 of 3
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd3, base, sec);
    serve("crcerr", CMD18_SEL, sec, 8'h00, 10);
    push_block(1'b1, 8'h00, 1'b0, 1'b1);
    push_block(1'b1, 8'h00, 1'b1, 1'b1);
    push_block(1'b1, 8'h00, 1'b0, 1'b0);
    serve("crcerr_stop", CMD12_SEL, 32'h0, 8'h00, 20000);
    wait_done("crcerr", 10, n);
    finish_case("crcerr", ST_CRC_ERR, 2);

    // reset in the middle of a block
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd2, base, sec);
    serve("rstmid", CMD18_SEL, sec, 8'h00, 10);
    push_block(1'b1, 8'h00, 1'b0, 1'b1);
    n = 0;
    while (wr_addr_q.size() < 200 && n < 5000) begin @(posedge i_clk); #1; n++; end
    check("rstmid_reached_byte200", wr_addr_q.size(), 200);
    #2 i_rst_n = 1'b0;
    #1;
    check("rstmid_out_a", {o_data, o_addr, o_wr_nrd, o_send_cmd, o_cmd_select}, '0);
    check("rstmid_out_b", {o_cmd_arg, o_read_done, o_status, o_busy}, '0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    stream.delete();
    repeat (30) begin @(posedge i_clk); #1; end
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_no_cmd12", cmd_cnt, 1);

    // clean run after the reset
    base = $urandom; sec = $urandom;
    new_case(base);
    start(8'd1, base, sec);
    serve("after_rst", CMD17_SEL, sec, 8'h00, 10);
    push_block(1'b1, 8'h00, 1'b0, 1'b1);
    wait_done("after_rst", 6000, n);
    finish_case("after_rst", ST_OK, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
